// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg : shared widths and forward-select encoding for the ID/EX stage   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  localparam int          XLEN     = 32;
  localparam int          CTRL_W   = 8;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | operand_fwd_mux : priority bypass select (EX > MEM > WB > RF) for one source |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module operand_fwd_mux #(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic [4:0]         i_rs,
  input  logic [XLEN-1:0]    i_rf_data,
  input  logic               i_ex_en,
  input  logic [4:0]         i_ex_rd,
  input  logic [XLEN-1:0]    i_ex_data,
  input  logic               i_mem_en,
  input  logic [4:0]         i_mem_rd,
  input  logic [XLEN-1:0]    i_mem_data,
  input  logic               i_wb_en,
  input  logic [4:0]         i_wb_rd,
  input  logic [XLEN-1:0]    i_wb_data,
  output logic [XLEN-1:0]    o_value,
  output pipe_pkg::fwd_sel_t o_sel
);
  import pipe_pkg::*;

  always_comb begin
    o_sel   = FWD_RF;
    o_value = i_rf_data;
    // x0 is hardwired: never bypassed, always reads as zero
    if (i_rs == REG_ZERO) begin
      o_value = '0;
    end else if (i_ex_en && (i_ex_rd == i_rs)) begin
      o_sel   = FWD_EX;
      o_value = i_ex_data;
    end else if (i_mem_en && (i_mem_rd == i_rs)) begin
      o_sel   = FWD_MEM;
      o_value = i_mem_data;
    end else if (i_wb_en && (i_wb_rd == i_rs)) begin
      o_sel   = FWD_WB;
      o_value = i_wb_data;
    end
  end

endmodule : operand_fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with bypass, load-use interlock,      |
// |               flush and EX backpressure. OPERAND_FORWARD_EN enables bypass.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_is_load,
  output logic              ex_reg_write,
  output logic [31:0]       stall_cycles
);
  import pipe_pkg::*;

`ifdef OPERAND_FORWARD_EN
  localparam logic c_FWD_EN = 1'b1;
`else
  localparam logic c_FWD_EN = 1'b0;
`endif

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc, r_ex_op1, r_ex_op2, r_ex_imm;
  logic [4:0]        r_ex_rd;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic              r_ex_is_load, r_ex_reg_write;
  logic [31:0]       r_stall_cnt;

  logic              w_free, w_hazard, w_transfer;
  logic [XLEN-1:0]   w_op1, w_op2;
  fwd_sel_t          w_sel1, w_sel2;
  logic              w_ex_writer, w_ex_fwd_en;

  assign w_free      = !r_ex_valid || ex_ready;
  assign w_ex_writer = r_ex_valid && r_ex_reg_write;
  // a load's data is not available in EX, so it is never a bypass source
  assign w_ex_fwd_en = c_FWD_EN && w_ex_writer && !r_ex_is_load;

`ifdef OPERAND_FORWARD_EN
  assign w_hazard = w_ex_writer && r_ex_is_load && (r_ex_rd != REG_ZERO) &&
                    ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
`else
  function automatic logic f_writer_hit(input logic [4:0] rs);
    return (rs != REG_ZERO) &&
           ((w_ex_writer && (r_ex_rd == rs)) ||
            (mem_reg_write && (mem_rd == rs)) ||
            (wb_reg_write && (wb_rd == rs)));
  endfunction
  assign w_hazard = f_writer_hit(id_rs1) || f_writer_hit(id_rs2);
`endif

  assign id_ready   = w_free && !w_hazard;
  assign w_transfer = id_valid && id_ready;

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_op1 (
    .i_rs(id_rs1), .i_rf_data(id_rd1),
    .i_ex_en(w_ex_fwd_en), .i_ex_rd(r_ex_rd), .i_ex_data(ex_result),
    .i_mem_en(c_FWD_EN && mem_reg_write), .i_mem_rd(mem_rd), .i_mem_data(mem_result),
    .i_wb_en(c_FWD_EN && wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_value(w_op1), .o_sel(w_sel1)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_op2 (
    .i_rs(id_rs2), .i_rf_data(id_rd2),
    .i_ex_en(w_ex_fwd_en), .i_ex_rd(r_ex_rd), .i_ex_data(ex_result),
    .i_mem_en(c_FWD_EN && mem_reg_write), .i_mem_rd(mem_rd), .i_mem_data(mem_result),
    .i_wb_en(c_FWD_EN && wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_value(w_op2), .o_sel(w_sel2)
  );

  // select codes are for observation only
  logic w_unused_sel;
  assign w_unused_sel = ^{w_sel1, w_sel2};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_op1       <= '0;
      r_ex_op2       <= '0;
      r_ex_imm       <= '0;
      r_ex_rd        <= '0;
      r_ex_ctrl      <= '0;
      r_ex_is_load   <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end else if (flush) begin
      r_ex_valid     <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end else if (w_transfer) begin
      r_ex_valid     <= 1'b1;
      r_ex_pc        <= id_pc;
      r_ex_op1       <= w_op1;
      r_ex_op2       <= w_op2;
      r_ex_imm       <= id_imm;
      r_ex_rd        <= id_rd;
      r_ex_ctrl      <= id_ctrl;
      r_ex_is_load   <= id_is_load;
      r_ex_reg_write <= id_reg_write;
    end else if (w_free) begin
      r_ex_valid     <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (id_valid && !id_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_ex_pc;
  assign ex_op1       = r_ex_op1;
  assign ex_op2       = r_ex_op2;
  assign ex_imm       = r_ex_imm;
  assign ex_rd        = r_ex_rd;
  assign ex_ctrl      = r_ex_ctrl;
  assign ex_is_load   = r_ex_is_load;
  assign ex_reg_write = r_ex_reg_write;
  assign stall_cycles = r_stall_cnt;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_ex_stage : directed self-checking bench for id_ex_stage              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [7:0]  id_ctrl;
  logic        id_is_load, id_reg_write;
  logic        flush, ex_ready;
  logic [31:0] ex_result, mem_result, wb_data;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic        ex_valid, ex_is_load, ex_reg_write;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm, stall_cycles;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_stall;
  logic [31:0] hold_pc, hold_op1;

  always #5 CLK = ~CLK;

  id_ex_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready), .ex_result(ex_result),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic ld, input logic rw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = d1; id_rd2 = d2; id_is_load = ld; id_reg_write = rw;
  endtask

  initial begin
    RST_N = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    id_imm = 32'h0; id_ctrl = 8'h0;
    ex_result = 32'h0; mem_result = 32'h0; wb_data = 32'h0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;

    #3;
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_stall", stall_cycles, 32'd0);
    chk("reset_ex_pc", ex_pc, 32'd0);
    #5 RST_N = 1'b1;

    // plain transfer: rs1=3 reads 0x11, rs2=x0, writes x5
    set_id(1'b1, 32'h100, 5'd3, 5'd0, 5'd5, 32'h11, 32'h22, 1'b0, 1'b1);
    id_imm = 32'h5; id_ctrl = 8'hA5;
    #1 chk("plain_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("plain_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("plain_ex_op1", ex_op1, 32'h11);
    chk("plain_ex_op2_x0", ex_op2, 32'h0);
    chk("plain_ex_pc", ex_pc, 32'h100);
    chk("plain_ex_imm", ex_imm, 32'h5);
    chk("plain_ex_ctrl", {24'd0, ex_ctrl}, 32'hA5);
    chk("plain_ex_rd", {27'd0, ex_rd}, 32'd5);

`ifdef OPERAND_FORWARD_EN
    // EX (x5 writer) > MEM > WB priority
    set_id(1'b1, 32'h200, 5'd5, 5'd0, 5'd5, 32'h55, 32'h0, 1'b0, 1'b0);
    ex_result = 32'hA; mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'hB;
    wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'hC;
    tick();
    chk("fwd_ex", ex_op1, 32'hA);
    tick();
    chk("fwd_mem", ex_op1, 32'hB);
    mem_reg_write = 1'b0;
    tick();
    chk("fwd_wb", ex_op1, 32'hC);
    id_rs1 = 5'd0;
    tick();
    chk("fwd_x0", ex_op1, 32'h0);
    wb_reg_write = 1'b0;
    // load to x7, then a consumer of x7 on rs2
    set_id(1'b1, 32'h204, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h104, 5'd0, 5'd7, 5'd10, 32'h0, 32'h77, 1'b0, 1'b1);
    #1 chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall", stall_cycles, 32'd1);
    mem_rd = 5'd7; mem_reg_write = 1'b1; mem_result = 32'h55;
    #1 chk("lu_ready_after", {31'd0, id_ready}, 32'd1);
    tick();
    chk("lu_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_ex_op2", ex_op2, 32'h55);
    mem_reg_write = 1'b0;
    exp_stall = 32'd1; hold_pc = 32'h104; hold_op1 = 32'h0;
`else
    // x5 writer walks EX -> MEM -> WB; consumer waits 3 bubbles, no bypass
    set_id(1'b1, 32'h104, 5'd5, 5'd0, 5'd10, 32'h44, 32'h99, 1'b0, 1'b1);
    ex_result = 32'hDEAD0001; mem_result = 32'hDEAD0002; wb_data = 32'hDEAD0003;
    #1 chk("nf_ready_ex", {31'd0, id_ready}, 32'd0);
    tick();
    chk("nf_bubble1", {31'd0, ex_valid}, 32'd0);
    chk("nf_stall1", stall_cycles, 32'd1);
    mem_rd = 5'd5; mem_reg_write = 1'b1;
    #1 chk("nf_ready_mem", {31'd0, id_ready}, 32'd0);
    tick();
    chk("nf_stall2", stall_cycles, 32'd2);
    mem_reg_write = 1'b0; wb_rd = 5'd5; wb_reg_write = 1'b1;
    #1 chk("nf_ready_wb", {31'd0, id_ready}, 32'd0);
    tick();
    chk("nf_bubble3", {31'd0, ex_valid}, 32'd0);
    chk("nf_stall3", stall_cycles, 32'd3);
    wb_reg_write = 1'b0;
    #1 chk("nf_ready_clear", {31'd0, id_ready}, 32'd1);
    tick();
    chk("nf_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("nf_ex_op1_rf", ex_op1, 32'h44);
    chk("nf_ex_pc", ex_pc, 32'h104);
    // writers present but ignored for operand values
    exp_stall = 32'd3; hold_pc = 32'h104; hold_op1 = 32'h44;
`endif

    // backpressure: 3 cycles of hold
    set_id(1'b1, 32'h108, 5'd1, 5'd2, 5'd11, 32'h1111, 32'h2222, 1'b0, 1'b1);
    ex_ready = 1'b0;
    #1 chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
    tick(); tick(); tick();
    chk("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("bp_ex_pc", ex_pc, hold_pc);
    chk("bp_ex_op1", ex_op1, hold_op1);
    chk("bp_stall", stall_cycles, exp_stall + 32'd3);

    // flush during hold; stall still counts
    flush = 1'b1;
    tick();
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("flush_stall", stall_cycles, exp_stall + 32'd4);
    flush = 1'b0;
    #1 chk("post_flush_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("post_flush_op1", ex_op1, 32'h1111);
    chk("post_flush_op2", ex_op2, 32'h2222);
    chk("post_flush_pc", ex_pc, 32'h108);

    // x0 sources read as zero; load flag propagates
    ex_ready = 1'b1;
    set_id(1'b1, 32'h10C, 5'd0, 5'd0, 5'd12, 32'hFFFF, 32'hEEEE, 1'b1, 1'b1);
    tick();
    chk("x0_op1", ex_op1, 32'h0);
    chk("x0_op2", ex_op2, 32'h0);
    chk("x0_is_load", {31'd0, ex_is_load}, 32'd1);

    // bubble zeroes the flags
    id_valid = 1'b0;
    tick();
    chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("bubble_is_load", {31'd0, ex_is_load}, 32'd0);
    chk("bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);

    // reset mid-stream, away from any clock edge
    set_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_reset_stall", stall_cycles, 32'd0);
    chk("async_reset_pc", ex_pc, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
